parquimetro_stimgen: RTL and testbench

Synthesizable sensor-pattern generator driving the two vehicle sensors (psensor, ssensor) of the parking-meter counter. It is the transmitter end of the sensor interface. On command it plays a car entering, leaving, balking, or a deliberately illegal glitch, each phase held a programmable number of cycles. It also keeps the reference occupancy the meter's conteo must match. It sits in front of the meter in the on-board self-test path and doubles as the bench stimulus source.

---
 rtl/parquimetro_pkg.sv | 49 ++++
 rtl/parquimetro_dwell_cnt.sv | 34 +++
 rtl/parquimetro_stimgen.sv | 123 ++++++++++++
 tb/tb_parquimetro_stimgen.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/parquimetro_pkg.sv
// Shared types and helpers for the parking-meter sensor stimulus generator.
// The pattern lookup is also used by the meter-side checker.
package parquimetro_pkg;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;

  localparam logic [CW-1:0] OCC_MAX = {CW{1'b1}};

  typedef enum logic [1:0] {
    CMD_ENTER  = 2'b00,
    CMD_EXIT   = 2'b01,
    CMD_BALK   = 2'b10,
    CMD_GLITCH = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PH1  = 3'd1,
    S_PH2  = 3'd2,
    S_PH3  = 3'd3,
    S_GAP  = 3'd4
  } state_e;

  // Latched command plus its effective dwell minus one (phase counter reload value)
  typedef struct packed {
    cmd_e          cmd;
    logic [DW-1:0] dwell_m1;
  } seq_cfg_t;

  // {psensor, ssensor} for a command in a given phase; IDLE and GAP are quiet
  function automatic logic [1:0] sensor_pattern(input cmd_e cmd, input state_e phase);
    logic [1:0] pat;
    pat = 2'b00;
    case (phase)
      S_PH1: pat = (cmd == CMD_EXIT) ? 2'b01 : 2'b10;
      S_PH2: pat = (cmd == CMD_GLITCH) ? 2'b00 : 2'b11;
      S_PH3: begin
        case (cmd)
          CMD_ENTER, CMD_GLITCH: pat = 2'b01;
          default:               pat = 2'b10;
        endcase
      end
      default: pat = 2'b00;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/parquimetro_dwell_cnt.sv
// Loadable down-counter timing each sequence phase; holds at zero.
module parquimetro_dwell_cnt
  import parquimetro_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [DW-1:0] value,
  output logic          zero_c
);

  logic [DW-1:0] count_q;
  logic [DW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (count_q != '0) begin
      count_d = count_q - DW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_c = (count_q == '0);

endmodule

// File: rtl/parquimetro_stimgen.sv
// Sensor-pattern generator: plays ENTER/EXIT/BALK/GLITCH sequences on the meter
// sensors and tracks the occupancy the meter is expected to report.
module parquimetro_stimgen
  import parquimetro_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  input  logic [1:0]    cmd,
  input  logic [DW-1:0] dwell,
  output logic          cmd_ready,
  output logic          psensor,
  output logic          ssensor,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] occupancy
);

  state_e        state_q, state_d;
  seq_cfg_t      cfg_q, cfg_d;
  logic [1:0]    sens_q, sens_d;
  logic [CW-1:0] occ_q, occ_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          cnt_load;
  logic          cnt_zero_c;
  logic [DW-1:0] dwell_eff_m1;

  // Dwell of zero behaves as one cycle per phase
  assign dwell_eff_m1 = (dwell == '0) ? '0 : (dwell - DW'(1));

  parquimetro_dwell_cnt u_dwell_cnt (
    .clk    (clk),
    .reset  (reset),
    .load   (cnt_load),
    .value  (cfg_d.dwell_m1),
    .zero_c (cnt_zero_c)
  );

  always_comb begin
    state_d  = state_q;
    cfg_d    = cfg_q;
    occ_d    = occ_q;
    done_d   = 1'b0;
    cnt_load = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && ready_q) begin
          cfg_d.cmd      = cmd_e'(cmd);
          cfg_d.dwell_m1 = dwell_eff_m1;
          cnt_load       = 1'b1;
          state_d        = S_PH1;
        end
      end
      S_PH1: begin
        if (cnt_zero_c) begin
          cnt_load = 1'b1;
          state_d  = S_PH2;
        end
      end
      S_PH2: begin
        if (cnt_zero_c) begin
          cnt_load = 1'b1;
          state_d  = S_PH3;
        end
      end
      S_PH3: begin
        if (cnt_zero_c) begin
          cnt_load = 1'b1;
          state_d  = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_zero_c) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          // Occupancy commits together with done; aborted sequences never reach here
          case (cfg_q.cmd)
            CMD_ENTER: if (occ_q != OCC_MAX) occ_d = occ_q + CW'(1);
            CMD_EXIT:  if (occ_q != '0)      occ_d = occ_q - CW'(1);
            default:   occ_d = occ_q;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase

    sens_d  = sensor_pattern(cfg_d.cmd, state_d);
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cfg_q   <= '{cmd: CMD_ENTER, dwell_m1: '0};
      sens_q  <= 2'b00;
      occ_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      sens_q  <= sens_d;
      occ_q   <= occ_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign cmd_ready = ready_q;
  assign psensor   = sens_q[1];
  assign ssensor   = sens_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_parquimetro_stimgen.sv
// Directed + randomized bench for parquimetro_stimgen against a sequence-level model.
module tb_parquimetro_stimgen;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic [1:0] cmd;
  logic [7:0] dwell;
  logic       cmd_ready;
  logic       psensor;
  logic       ssensor;
  logic       busy;
  logic       done;
  logic [3:0] occupancy;

  int tests = 0;
  int fails = 0;
  int model_occ = 0;

  parquimetro_stimgen dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .dwell     (dwell),
    .cmd_ready (cmd_ready),
    .psensor   (psensor),
    .ssensor   (ssensor),
    .busy      (busy),
    .done      (done),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Expected {p,s} for command c in phase ph (0..2 active, 3 = gap)
  function automatic logic [1:0] exp_pat(input int c, input int ph);
    logic [5:0] seq;
    case (c)
      0:       seq = 6'b10_11_01;
      1:       seq = 6'b01_11_10;
      2:       seq = 6'b10_11_10;
      default: seq = 6'b10_00_01;
    endcase
    if (ph >= 3) return 2'b00;
    return seq[5-2*ph -: 2];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    check("rst_sensors", 32'({psensor, ssensor}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_occ", 32'(occupancy), 32'd0);
    model_occ = 0;
    tick();
    reset = 1'b1;
    check("rst_ready", 32'(cmd_ready), 32'd1);
  endtask

  // Issue one command now and follow it to its done cycle; returns in that cycle
  task automatic run_seq(input int c, input int dw);
    int eff;
    eff = (dw == 0) ? 1 : dw;
    check("ready_pre", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd       = 2'(c);
    dwell     = 8'(dw);
    tick();
    for (int ph = 0; ph < 4; ph++) begin
      for (int k = 0; k < eff; k++) begin
        check("sensors", 32'({psensor, ssensor}), 32'(exp_pat(c, ph)));
        check("busy", 32'(busy), 32'd1);
        check("ready_busy", 32'(cmd_ready), 32'd0);
        check("done_early", 32'(done), 32'd0);
        cmd_valid = 1'($urandom_range(0, 1));
        cmd       = 2'($urandom);
        dwell     = 8'($urandom);
        tick();
      end
    end
    cmd_valid = 1'b0;
    if (c == 0 && model_occ < 15) model_occ++;
    else if (c == 1 && model_occ > 0) model_occ--;
    check("done", 32'(done), 32'd1);
    check("busy_done", 32'(busy), 32'd0);
    check("ready_done", 32'(cmd_ready), 32'd1);
    check("sensors_done", 32'({psensor, ssensor}), 32'd0);
    check("occ", 32'(occupancy), 32'(model_occ));
  endtask

  task automatic idle_tick();
    tick();
    check("idle_done", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_ready", 32'(cmd_ready), 32'd1);
    check("idle_sensors", 32'({psensor, ssensor}), 32'd0);
    check("idle_occ", 32'(occupancy), 32'(model_occ));
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd       = 2'b00;
    dwell     = 8'd0;
    #1;
    do_reset();
    idle_tick();

    // ENTER, dwell 3: 12 busy cycles then done
    run_seq(0, 3);
    idle_tick();

    // Back-to-back ENTER x3, EXIT, dwell 1, each issued in the done cycle
    do_reset();
    run_seq(0, 1);
    run_seq(0, 1);
    run_seq(0, 1);
    run_seq(1, 1);
    check("b2b_occ", 32'(occupancy), 32'd2);
    idle_tick();

    // Underflow guard and no-change commands
    do_reset();
    run_seq(1, 2);
    run_seq(2, 2);
    run_seq(3, 2);
    check("noop_occ", 32'(occupancy), 32'd0);
    idle_tick();

    // Saturation at 15
    for (int i = 0; i < 17; i++) run_seq(0, $urandom_range(1, 2));
    check("sat_occ", 32'(occupancy), 32'd15);
    idle_tick();

    // dwell 0 behaves as 1
    run_seq(1, 0);
    run_seq(0, 0);
    idle_tick();

    // Random command mix
    for (int i = 0; i < 24; i++) begin
      run_seq(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
      if ($urandom_range(0, 1) == 1) idle_tick();
    end
    idle_tick();

    // Longest legal dwell
    run_seq(2, 255);
    idle_tick();

    // Reset mid-PH2 of an ENTER at occupancy 5
    do_reset();
    for (int i = 0; i < 5; i++) run_seq(0, 1);
    check("pre_abort_occ", 32'(occupancy), 32'd5);
    cmd_valid = 1'b1;
    cmd       = 2'b00;
    dwell     = 8'd4;
    tick();
    cmd_valid = 1'b0;
    repeat (5) tick();
    check("abort_in_ph2", 32'({psensor, ssensor}), 32'(exp_pat(0, 1)));
    do_reset();
    idle_tick();
    run_seq(0, 2);
    idle_tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
